ps2_rx_fifo: RTL and testbench

//  Parametrised PS/2 keyboard receiver. Fully synchronous to clk, with parity/stop checking,

---
 rtl/ps2_rx_fifo_if.sv | 29 ++
 rtl/ps2_rx_fifo.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: CPU-side bus of the PS/2 keyboard receiver.
//   ren        master -> slave  pop the head entry (ignored when empty)
//   data       slave -> master  head entry {ext, rel, 6'b0, scan[7:0]}, 0 when empty
//   ready      slave -> master  FIFO not empty
//   count      slave -> master  entries held, 0..DEPTH
//   overflow   slave -> master  sticky dropped-event flag, cleared by a pop
//   frame_err  slave -> master  one-cycle pulse on parity/stop/timeout error
interface ps2_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ren;
  logic [15:0]   data;
  logic          ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          frame_err;

  modport master (
    output ren,
    input  data, ready, count, overflow, frame_err
  );

  modport slave (
    input  ren,
    output data, ready, count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with pin filtering, frame checking,
// timeout, E0/F0 prefix folding and a show-ahead FIFO of key events.
// Everything runs on clk; the PS/2 clock pin is only ever sampled.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ps2_clk_i   raw PS/2 clock pin (asynchronous)
//   ps2_data_i  raw PS/2 data pin (asynchronous)
//   bus         CPU-side FIFO interface (slave modport)
module ps2_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int FILTER_CYCLES  = 19,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  ps2_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // ---------------------------------------------------------------------
  // Input path: bit 1 = ps2 clock, bit 0 = ps2 data
  // ---------------------------------------------------------------------
  logic [1:0]         s1_q, s2_q;
  logic [1:0]         filt_q;
  logic [1:0][FW-1:0] fcnt_q;
  logic               fclk_prev_q;
  logic               fclk, fdata, samp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= {ps2_clk_i, ps2_data_i};
      s2_q <= s1_q;
    end
  end

  // The filtered value follows the synchronised pin only once the pin has
  // disagreed with it for FILTER_CYCLES samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_CYCLES - 1)) begin
          filt_q[i] <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fclk_prev_q <= 1'b1;
    else        fclk_prev_q <= filt_q[1];
  end

  assign fclk  = filt_q[1];
  assign fdata = filt_q[0];
  assign samp  = fclk_prev_q & ~fclk;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bidx_q,  bidx_d;
  logic          par_q,   par_d;
  logic [TW-1:0] tmo_q,   tmo_d;
  logic          vld_q,   vld_d;
  logic          err_q,   err_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bidx_d  = bidx_q;
    par_d   = par_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q == S_IDLE || samp) tmo_d = '0;
    else                           tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (samp && !fdata) begin
          state_d = S_DATA;
          bidx_d  = 3'd0;
        end
      end
      S_DATA: begin
        if (samp) begin
          shift_d = {fdata, shift_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (samp) begin
          par_d   = fdata;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (samp) begin
          state_d = S_IDLE;
          // odd parity across data + parity bit, and a high stop bit
          if (fdata && (^{shift_q, par_q})) vld_d = 1'b1;
          else                              err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort a stalled frame; a sample event on this cycle takes precedence.
    if (state_q != S_IDLE && !samp && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bidx_q  <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Prefix folding. vld_q is the cycle after the STOP sample; shift_q still
  // holds the byte because the FSM sits in IDLE until the next start bit.
  // ---------------------------------------------------------------------
  logic ext_q, ext_d, rel_q, rel_d;
  logic is_e0, is_f0, push;

  assign is_e0 = (shift_q == 8'hE0);
  assign is_f0 = (shift_q == 8'hF0);
  assign push  = vld_q & ~is_e0 & ~is_f0;

  always_comb begin
    ext_d = ext_q;
    rel_d = rel_q;
    if (err_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (vld_q) begin
      if (is_e0)      ext_d = 1'b1;
      else if (is_f0) rel_d = 1'b1;
      else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      rel_q <= rel_d;
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO; entries stored as {ext, rel, scan}
  // ---------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, pop, wr, drop;
  logic [9:0]    head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = bus.ren & ~empty;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wptr_d  = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CW'(wr) - CW'(pop);
    ovf_d   = ovf_q;
    if (pop)       ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= {ext_q, rel_q, shift_q};
  end

  assign head          = mem[rptr_q];
  assign bus.data      = empty ? 16'h0000 : {head[9], head[8], 6'b0, head[7:0]};
  assign bus.ready     = ~empty;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a table of short frame sequences that each
// leave one event in the FIFO, plus hand-written multi-cycle sequences for
// timeout, overflow, glitch rejection and mid-frame reset.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 16;
  localparam int FILT  = 19;
  localparam int TMO   = 400;
  localparam int HP    = 30;   // PS/2 half bit period in clk cycles
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  ps2_rx_fifo #(
    .DEPTH(DEPTH), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int   pass_cnt = 0;
  int   tot = 0;
  int   errs = 0;
  int   wide = 0;
  logic err_prev = 1'b0;

  // count frame_err pulses and any pulse lasting longer than one cycle
  always @(negedge clk) begin
    if (bus.frame_err) begin
      errs++;
      if (err_prev) wide++;
    end
    err_prev = bus.frame_err;
  end

  typedef struct {
    int          n;
    logic [7:0]  b [3];
    logic [2:0]  bad;     // per-frame parity flip
    logic [15:0] exp;
    int          nerr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HP);
    ps2_clk = 1'b0;
    tick(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic badpar);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ badpar);
    ps2_bit(1'b1);
    tick(HP);
  endtask

  task automatic pop();
    @(posedge clk);
    #1 bus.ren = 1'b1;
    tick(1);
    bus.ren = 1'b0;
  endtask

  task automatic chk_empty(input string nm);
    @(negedge clk);
    chk({nm, " data"},  32'(bus.data),  32'h0);
    chk({nm, " ready"}, 32'(bus.ready), 32'h0);
    chk({nm, " count"}, 32'(bus.count), 32'h0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vecs[0] = '{1, '{8'h1C, 8'h00, 8'h00}, 3'b000, 16'h001C, 0};
    vecs[1] = '{3, '{8'hE0, 8'hF0, 8'h75}, 3'b000, 16'hC075, 0};
    vecs[2] = '{2, '{8'hE0, 8'h75, 8'h00}, 3'b000, 16'h8075, 0};
    vecs[3] = '{2, '{8'hF0, 8'h75, 8'h00}, 3'b000, 16'h4075, 0};
    vecs[4] = '{1, '{8'hE1, 8'h00, 8'h00}, 3'b000, 16'h00E1, 0};
    vecs[5] = '{3, '{8'hE0, 8'h12, 8'h75}, 3'b010, 16'h0075, 1};
    vecs[6] = '{2, '{8'h1C, 8'h1C, 8'h00}, 3'b001, 16'h001C, 1};

    bus.ren = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst overflow",  32'(bus.overflow),  32'h0);
    chk("rst frame_err", 32'(bus.frame_err), 32'h0);
    chk_empty("rst");
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk_empty("post-rst");

    // table-driven single-event sequences
    foreach (vecs[v]) begin
      e0 = errs;
      for (int f = 0; f < vecs[v].n; f++) begin
        frame(vecs[v].b[f], vecs[v].bad[f]);
        if (f < vecs[v].n - 1) begin
          @(negedge clk);
          chk($sformatf("v%0d mid count", v), 32'(bus.count), 32'h0);
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d data", v),  32'(bus.data),  32'(vecs[v].exp));
      chk($sformatf("v%0d ready", v), 32'(bus.ready), 32'h1);
      chk($sformatf("v%0d count", v), 32'(bus.count), 32'h1);
      chk($sformatf("v%0d errs", v),  32'(errs - e0), 32'(vecs[v].nerr));
      pop();
      chk_empty($sformatf("v%0d pop", v));
    end

    // folded event followed by a plain one
    frame(8'hE0, 1'b0);
    frame(8'hF0, 1'b0);
    frame(8'h75, 1'b0);
    frame(8'h75, 1'b0);
    @(negedge clk);
    chk("fold2 count", 32'(bus.count), 32'h2);
    chk("fold2 head0", 32'(bus.data),  32'hC075);
    pop();
    @(negedge clk);
    chk("fold2 head1", 32'(bus.data),  32'h0075);
    pop();
    chk_empty("fold2");

    // ren on empty FIFO has no effect
    pop();
    chk_empty("empty ren");
    @(negedge clk);
    chk("empty ren ovf", 32'(bus.overflow), 32'h0);

    // timeout after start + 4 bits
    e0 = errs;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    tick(TMO + 100);
    @(negedge clk);
    chk("tmo errs",  32'(errs - e0), 32'h1);
    chk("tmo count", 32'(bus.count), 32'h0);
    frame(8'h29, 1'b0);
    @(negedge clk);
    chk("tmo next data",  32'(bus.data),  32'h0029);
    chk("tmo next count", 32'(bus.count), 32'h1);
    pop();
    chk_empty("tmo pop");

    // short ps2_clk glitch with data low must not start a frame
    ps2_data = 1'b0;
    tick(5);
    ps2_clk = 1'b0;
    tick(FILT - 2);
    ps2_clk = 1'b1;
    tick(40);
    ps2_data = 1'b1;
    tick(40);
    frame(8'h33, 1'b0);
    @(negedge clk);
    chk("glitch data",  32'(bus.data),  32'h0033);
    chk("glitch count", 32'(bus.count), 32'h1);

    // reset mid-frame with an entry held
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    rst_n = 1'b0;
    tick(3);
    chk_empty("midrst");
    rst_n = 1'b1;
    tick(HP);
    frame(8'h5A, 1'b0);
    @(negedge clk);
    chk("midrst next data",  32'(bus.data),  32'h005A);
    chk("midrst next count", 32'(bus.count), 32'h1);
    pop();
    chk_empty("midrst pop");

    // overflow: DEPTH+1 events without reading
    for (int i = 1; i <= DEPTH + 1; i++) frame(8'(i), 1'b0);
    @(negedge clk);
    chk("ovf count", 32'(bus.count),    32'(DEPTH));
    chk("ovf flag",  32'(bus.overflow), 32'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("ovf pop%0d", i), 32'(bus.data), 32'(i));
      pop();
      if (i == 1) begin
        @(negedge clk);
        chk("ovf clear", 32'(bus.overflow), 32'h0);
        chk("ovf count after pop", 32'(bus.count), 32'(DEPTH - 1));
      end
    end
    chk_empty("ovf drained");

    @(negedge clk);
    chk("err pulse width", 32'(wide), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
